// File: rtl/cr_osf_ob_stats_pkg.sv
// Shared OSF package: outbound-stats FSM state encoding and beat geometry.
package cr_osfPKG;

  typedef enum logic {
    OB_IDLE     = 1'b0,
    OB_IN_FRAME = 1'b1
  } osf_ob_stats_state_e;

  localparam int unsigned OSF_OB_BEAT_BYTES = 8;
  localparam int unsigned OSF_OB_AMT_W      = 4;

endpackage

// File: rtl/cr_osf_ob_stats.sv
// Passive outbound beat monitor: byte/frame count strobes for the regfile,
// last completed frame length and framing error pulses.
module cr_osf_ob_stats
  import cr_osfPKG::*;
#(
  parameter int unsigned N_FRAME_LEN_BITS = 24,
  parameter int unsigned BEAT_BYTES       = OSF_OB_BEAT_BYTES
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ob_valid,
  input  logic                        ob_ready,
  input  logic                        ob_sob,
  input  logic                        ob_eob,
  input  logic [3:0]                  ob_bytes_vld,
  input  logic                        stats_en,
  output logic                        ob_bytes_cnt_stb,
  output logic [3:0]                  ob_bytes_cnt_amt,
  output logic                        ob_frame_cnt_stb,
  output logic [N_FRAME_LEN_BITS-1:0] last_frame_bytes,
  output logic                        frame_err_stb,
  output logic                        in_frame
);

  localparam int unsigned LW = N_FRAME_LEN_BITS;
  localparam int unsigned SW = ((LW > OSF_OB_AMT_W) ? LW : OSF_OB_AMT_W) + 1;
  localparam logic [LW-1:0] LEN_MAX = '1;
  localparam logic [3:0] BEAT_AMT = 4'(BEAT_BYTES);

  // Saturating length accumulate; never wraps past all-ones.
  function automatic logic [LW-1:0] sat_add(input logic [LW-1:0] a, input logic [3:0] b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SW'(LEN_MAX)) return LEN_MAX;
    return LW'(s);
  endfunction

  osf_ob_stats_state_e state, state_nxt;
  logic [LW-1:0] len, len_nxt;
  logic [LW-1:0] start_len, cont_len;
  logic [LW-1:0] lfb_nxt;
  logic [3:0]    amt, amt_nxt;
  logic          acc, clamp_err;
  logic          bstb_nxt, fstb_nxt, err_nxt;

  // Beat amount decode, next-state and length accumulation.
  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    lfb_nxt   = last_frame_bytes;
    amt_nxt   = '0;
    bstb_nxt  = 1'b0;
    fstb_nxt  = 1'b0;
    err_nxt   = 1'b0;
    amt       = BEAT_AMT;
    clamp_err = 1'b0;
    acc       = ob_valid & ob_ready;

    if (ob_eob && ob_bytes_vld != 4'd0) begin
      if (ob_bytes_vld > BEAT_AMT) clamp_err = 1'b1;
      else                         amt       = ob_bytes_vld;
    end
    start_len = sat_add('0, amt);
    cont_len  = sat_add(len, amt);

    if (acc) begin
      bstb_nxt = stats_en;
      amt_nxt  = amt;
      err_nxt  = clamp_err;
      // A sob inside a frame abandons it; a missing sob in IDLE opens one implicitly.
      if (state == OB_IDLE || ob_sob) begin
        if (state == OB_IDLE && !ob_sob)     err_nxt = 1'b1;
        if (state == OB_IN_FRAME && ob_sob)  err_nxt = 1'b1;
        len_nxt = start_len;
        if (ob_eob) begin
          state_nxt = OB_IDLE;
          fstb_nxt  = stats_en;
          lfb_nxt   = start_len;
        end else begin
          state_nxt = OB_IN_FRAME;
        end
      end else begin
        len_nxt = cont_len;
        if (ob_eob) begin
          state_nxt = OB_IDLE;
          fstb_nxt  = stats_en;
          lfb_nxt   = cont_len;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= OB_IDLE;
      len              <= '0;
      ob_bytes_cnt_stb <= 1'b0;
      ob_bytes_cnt_amt <= '0;
      ob_frame_cnt_stb <= 1'b0;
      last_frame_bytes <= '0;
      frame_err_stb    <= 1'b0;
      in_frame         <= 1'b0;
    end else begin
      state            <= state_nxt;
      len              <= len_nxt;
      ob_bytes_cnt_stb <= bstb_nxt;
      ob_bytes_cnt_amt <= amt_nxt;
      ob_frame_cnt_stb <= fstb_nxt;
      last_frame_bytes <= lfb_nxt;
      frame_err_stb    <= err_nxt;
      in_frame         <= (state_nxt == OB_IN_FRAME);
    end
  end

endmodule

// File: tb/tb_cr_osf_ob_stats.sv
// Bench for cr_osf_ob_stats: directed test-plan sequences then random beats,
// checked against a frame-level model; a 4-bit instance covers saturation.
module tb_cr_osf_ob_stats;

  logic clk = 1'b0;
  logic rst_n;
  logic ob_valid, ob_ready, ob_sob, ob_eob, stats_en;
  logic [3:0] ob_bytes_vld;

  logic a_bstb, a_fstb, a_err, a_inf;
  logic [3:0] a_amt;
  logic [23:0] a_lfb;
  logic b_bstb, b_fstb, b_err, b_inf;
  logic [3:0] b_amt;
  logic [3:0] b_lfb;

  int checks = 0;
  int failures = 0;

  // model state
  bit     m_open;
  longint m_len;
  bit     e_acc, e_bstb, e_fstb, e_err, e_inf;
  int     e_amt;
  longint e_lfb_a, e_lfb_b;

  always #5 clk = ~clk;

  cr_osf_ob_stats #(.N_FRAME_LEN_BITS(24)) u_a (
    .clk(clk), .rst_n(rst_n), .ob_valid(ob_valid), .ob_ready(ob_ready),
    .ob_sob(ob_sob), .ob_eob(ob_eob), .ob_bytes_vld(ob_bytes_vld), .stats_en(stats_en),
    .ob_bytes_cnt_stb(a_bstb), .ob_bytes_cnt_amt(a_amt), .ob_frame_cnt_stb(a_fstb),
    .last_frame_bytes(a_lfb), .frame_err_stb(a_err), .in_frame(a_inf));

  cr_osf_ob_stats #(.N_FRAME_LEN_BITS(4)) u_b (
    .clk(clk), .rst_n(rst_n), .ob_valid(ob_valid), .ob_ready(ob_ready),
    .ob_sob(ob_sob), .ob_eob(ob_eob), .ob_bytes_vld(ob_bytes_vld), .stats_en(stats_en),
    .ob_bytes_cnt_stb(b_bstb), .ob_bytes_cnt_amt(b_amt), .ob_frame_cnt_stb(b_fstb),
    .last_frame_bytes(b_lfb), .frame_err_stb(b_err), .in_frame(b_inf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("a_bytes_stb", 32'(a_bstb), 32'(e_bstb));
    chk("a_frame_stb", 32'(a_fstb), 32'(e_fstb));
    chk("a_err_stb",   32'(a_err),  32'(e_err));
    chk("a_in_frame",  32'(a_inf),  32'(e_inf));
    chk("a_last_len",  32'(a_lfb),  32'(e_lfb_a));
    chk("b_bytes_stb", 32'(b_bstb), 32'(e_bstb));
    chk("b_frame_stb", 32'(b_fstb), 32'(e_fstb));
    chk("b_last_len",  32'(b_lfb),  32'(e_lfb_b));
    if (e_acc) begin
      chk("a_bytes_amt", 32'(a_amt), 32'(e_amt));
      chk("b_bytes_amt", 32'(b_amt), 32'(e_amt));
    end
  endtask

  task automatic model_reset();
    m_open = 0; m_len = 0;
    e_acc = 0; e_bstb = 0; e_fstb = 0; e_err = 0; e_inf = 0;
    e_amt = 0; e_lfb_a = 0; e_lfb_b = 0;
  endtask

  // Frame-level reference: unbounded length, clipped to counter width at completion.
  task automatic model(input bit v, r, s, e, input int bv, input bit en);
    int a;
    bit err;
    e_acc = v & r;
    e_bstb = 0; e_fstb = 0; e_err = 0;
    if (!e_acc) return;
    err = 0;
    if (!e) a = 8;
    else if (bv == 0) a = 8;
    else if (bv > 8) begin a = 8; err = 1; end
    else a = bv;
    if (m_open == s) err = 1;
    if (s || !m_open) m_len = a; else m_len += a;
    if (e) begin
      e_fstb  = en;
      e_lfb_a = (m_len > 24'hFFFFFF) ? 24'hFFFFFF : m_len;
      e_lfb_b = (m_len > 15) ? 15 : m_len;
      m_open  = 0;
    end else begin
      m_open = 1;
    end
    e_bstb = en; e_amt = a; e_err = err; e_inf = m_open;
  endtask

  task automatic step(input bit v, r, s, e, input int bv, input bit en);
    @(negedge clk);
    check_outputs();
    ob_valid = v; ob_ready = r; ob_sob = s; ob_eob = e;
    ob_bytes_vld = 4'(bv); stats_en = en;
    model(v, r, s, e, bv, en);
  endtask

  task automatic idle();
    step(0, 1, 0, 0, 0, 1);
  endtask

  initial begin
    int bstb_seen;
    rst_n = 1'b0;
    ob_valid = 0; ob_ready = 0; ob_sob = 0; ob_eob = 0; ob_bytes_vld = '0; stats_en = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // normal frame: 8+8+8+3
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 1, 3, 1);
    idle();
    chk("normal_last_len", 32'(a_lfb), 32'd27);

    // backpressure: ready toggles, 3 beats accepted
    bstb_seen = 0;
    step(1, 0, 1, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1); bstb_seen += int'(a_bstb);
    step(1, 1, 0, 0, 0, 1); bstb_seen += int'(a_bstb);
    step(1, 0, 0, 1, 5, 1); bstb_seen += int'(a_bstb);
    step(1, 1, 0, 1, 5, 1); bstb_seen += int'(a_bstb);
    idle();                 bstb_seen += int'(a_bstb);
    chk("bp_strobe_count", 32'(bstb_seen), 32'd3);
    chk("bp_last_len", 32'(a_lfb), 32'd21);

    // single-beat frames and byte-count encoding
    step(1, 1, 1, 1, 0, 1);
    idle();
    chk("single_last_len", 32'(a_lfb), 32'd8);
    step(1, 1, 1, 1, 12, 1);
    idle();
    chk("clamp_amt", 32'(a_amt), 32'd8);
    chk("clamp_err", 32'(a_err), 32'd1);

    // sob mid-frame abandons the open frame
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 0, 1, 2, 1);
    idle();
    chk("restart_last_len", 32'(a_lfb), 32'd10);
    step(1, 1, 0, 1, 4, 1);
    idle();
    chk("orphan_last_len", 32'(a_lfb), 32'd4);

    // gated stats still track length
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 6, 0);
    idle();
    chk("gated_last_len", 32'(a_lfb), 32'd14);

    // saturation on the 4-bit instance
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 1, 0, 1);
    idle();
    chk("sat_last_len_b", 32'(b_lfb), 32'd15);
    chk("sat_last_len_a", 32'(a_lfb), 32'd24);

    // asynchronous reset mid-frame, then orphan eob
    step(1, 1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    @(negedge clk);
    check_outputs();
    ob_valid = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    rst_n = 1'b1;
    model(0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 1, 0, 1);
    idle();
    chk("post_reset_orphan_err", 32'(a_err), 32'd1);
    chk("post_reset_last_len", 32'(a_lfb), 32'd8);

    // random beats
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 9) < 2), ($urandom_range(0, 3) == 0),
           int'($urandom_range(0, 15)), ($urandom_range(0, 9) != 0));
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
